// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round count, FSM states and inverse S-box
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   rk_idx_t;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} inv_fsm_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254, which maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in GF(2^8)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    return gf_inv(y ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational single AES inverse round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk_in,
  input  logic         last_in,
  output logic [127:0] state_out
);

  block_t shifted;
  block_t subbed;
  block_t keyed;
  block_t mixed;

  // Inverse shift rows: out(r,c) = in(r,(c-r) mod 4), byte index 4c+r
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[(4*c + r)*8 +: 8] = state_in[(4*((c - r + 4) % 4) + r)*8 +: 8];
  end

  // Inverse sub bytes followed by the round-key XOR
  always_comb begin
    subbed = '0;
    for (int n = 0; n < 16; n++)
      subbed[n*8 +: 8] = inv_sbox(shifted[n*8 +: 8]);
    keyed = subbed ^ rk_in;
  end

  // Inverse mix columns, one column of four bytes at a time
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[(4*c + 0)*8 +: 8];
      a1 = keyed[(4*c + 1)*8 +: 8];
      a2 = keyed[(4*c + 2)*8 +: 8];
      a3 = keyed[(4*c + 3)*8 +: 8];
      mixed[(4*c + 0)*8 +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      mixed[(4*c + 1)*8 +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      mixed[(4*c + 2)*8 +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      mixed[(4*c + 3)*8 +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
  end

  // The last round skips inverse mix columns
  assign state_out = last_in ? keyed : mixed;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES-128 inverse-cipher controller; AES_INV_ABORT_EN adds abort
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_INV_ABORT_EN
  ,
  input  logic         abort
`endif
);

  inv_fsm_t fsm_q, fsm_d;
  rk_idx_t  rnd_q, rnd_d;
  block_t   state_q, state_d;
  block_t   out_data_q, out_data_d;
  logic     out_valid_q, out_valid_d;
  logic     last_round;
  block_t   round_out;

  assign last_round = (fsm_q == FINAL);

  aes_inv_round u_round (
    .state_in  (state_q),
    .rk_in     (rk_data),
    .last_in   (last_round),
    .state_out (round_out)
  );

  // Next-state, key index and handshake outputs from the current FSM state
  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    rk_idx      = rk_idx_t'(NR);
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          rnd_d   = rk_idx_t'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rk_idx  = rnd_q;
        state_d = round_out;
        if (rnd_q == 4'd1) fsm_d = FINAL;
        else               rnd_d = rnd_q - 4'd1;
      end
      FINAL: begin
        busy        = 1'b1;
        rk_idx      = 4'd0;
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
    endcase
`ifdef AES_INV_ABORT_EN
    // Abort wins over everything outside IDLE, including a coinciding out_ready
    if (abort && fsm_q != IDLE) begin
      fsm_d       = IDLE;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
`endif
  end

  // State, round counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb/tb_aes_inv_round_ctrl.sv - self-checking bench for aes_inv_round_ctrl
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT2     = 128'h0123456789abcdeffedcba9876543210;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  logic [127:0] key_store [0:15];
  logic [7:0]   sb     [0:255];
  logic [7:0]   inv_sb [0:255];

  int errs   = 0;
  int checks = 0;

  int           cyc = 0;
  int           m_t = -1;
  bit           live = 1'b0;
  logic [127:0] m_last;
  logic [127:0] m_pt;
  logic         ov_prev = 1'b0;
  int           busy_cnt = 0;
  int           acc_hist [$];
  int           hs_cyc   [$];
  logic [127:0] hs_data  [$];
  int           ov_rise  [$];

  assign rk_data = key_store[rk_idx];

  aes_inv_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES_INV_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errs);
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[n*8 +: 8] = s[(15 - n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] w;
    w = {v, v} << k;
    return w[15:8];
  endfunction

  // Forward S-box by brute-force inversion plus the FIPS affine map; inverse table by lookup
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_sb[sb[x]] = 8'(x);
  endtask

  task automatic ks_expand(input logic [127:0] key);
    logic [7:0] w [0:175];
    logic [7:0] t [0:3];
    logic [7:0] tmp;
    logic [7:0] rcon;
    for (int i = 0; i < 16; i++) w[i] = key[i*8 +: 8];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rcon;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rcon = gmul(rcon, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ t[j];
    end
    for (int r = 0; r < 16; r++) key_store[r] = '0;
    for (int r = 0; r < 11; r++)
      for (int n = 0; n < 16; n++) key_store[r][n*8 +: 8] = w[16*r + n];
  endtask

  // Textbook inverse cipher on a 16-byte array using whatever the key store holds
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0] s [0:15];
    logic [7:0] u [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int n = 0; n < 16; n++) s[n] = ct[n*8 +: 8] ^ key_store[10][n*8 +: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          u[4*((col + row) % 4) + row] = s[4*col + row];
      for (int n = 0; n < 16; n++) s[n] = inv_sb[u[n]] ^ key_store[rd][n*8 +: 8];
      if (rd > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*col+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*col+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*col+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[n*8 +: 8] = s[n];
    return res;
  endfunction

  // Timeline model: m_t counts cycles since accept (-1 idle, 1..9 rounds, 10 final, 11+ holding output)
  initial begin : compare_proc
    logic [3:0] exp_rk;
    bit         ab;
    forever begin
      @(negedge clk);
      cyc++;
      if (live) begin
        exp_rk = (m_t >= 1 && m_t <= 10) ? 4'(10 - m_t) : 4'd10;
        chk("in_ready",  128'(in_ready),  128'(m_t < 0));
        chk("busy",      128'(busy),      128'(m_t >= 1 && m_t <= 10));
        chk("rk_idx",    128'(rk_idx),    128'(exp_rk));
        chk("out_valid", 128'(out_valid), 128'(m_t >= 11));
        chk("out_data",  out_data,        m_last);
      end
      if (out_valid === 1'b1 && ov_prev !== 1'b1) ov_rise.push_back(cyc);
      ov_prev = out_valid;
      if (busy === 1'b1) busy_cnt++;
      ab = 1'b0;
`ifdef AES_INV_ABORT_EN
      ab = (abort === 1'b1) && (m_t >= 1);
`endif
      if (rst) begin
        m_t    = -1;
        m_last = '0;
        live   = 1'b1;
      end else if (live) begin
        if (ab) begin
          m_t = -1;
        end else if (m_t < 0) begin
          if (in_valid) begin
            m_t  = 1;
            m_pt = ref_decrypt(in_data);
            acc_hist.push_back(cyc);
          end
        end else if (m_t < 11) begin
          m_t++;
          if (m_t == 11) m_last = m_pt;
        end else if (out_ready) begin
          hs_cyc.push_back(cyc);
          hs_data.push_back(out_data);
          m_t = -1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int target, input string nm);
    int i;
    i = 0;
    while (acc_hist.size() < target && i < 200) begin step(1); i++; end
    chk({nm, "_accept_wait"}, 128'(acc_hist.size() >= target), 128'(1));
  endtask

  task automatic wait_hs(input int target, input string nm);
    int i;
    i = 0;
    while (hs_data.size() < target && i < 200) begin step(1); i++; end
    chk({nm, "_output_wait"}, 128'(hs_data.size() >= target), 128'(1));
  endtask

  task automatic wait_ov(input int target, input string nm);
    int i;
    i = 0;
    while (ov_rise.size() < target && i < 200) begin step(1); i++; end
    chk({nm, "_valid_wait"}, 128'(ov_rise.size() >= target), 128'(1));
  endtask

  initial begin : stimulus
    int base;
    int hbase;
    int b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif
    for (int r = 0; r < 16; r++) key_store[r] = '0;
    build_sbox();
    ks_expand(fips(C1_KEY));

    // Pin the reference model to published values
    chk("ref_inv_sbox_63", 128'(inv_sb[8'h63]), 128'(8'h00));
    chk("ref_sbox_53",     128'(sb[8'h53]),     128'(8'hed));
    chk("ref_rk10",        key_store[10],       fips(C1_RK10));
    chk("ref_c1_plain",    ref_decrypt(fips(C1_CT)), fips(C1_PT));

    step(2);
    rst = 1'b0;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  out_data,        128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rk_idx",    128'(rk_idx),    128'(10));
    step(1);

    // C.1 vector, then 20 cycles of backpressure with a second block waiting
    in_data  = fips(C1_CT);
    in_valid = 1'b1;
    wait_acc(1, "c1");
    in_data = fips(CT2);
    wait_ov(1, "c1");
    chk("c1_latency", 128'(ov_rise[0] - acc_hist[0]), 128'(11));
    chk("c1_plain",   out_data, fips(C1_PT));
    step(20);
    chk("bp_no_accept", 128'(acc_hist.size()), 128'(1));
    chk("bp_in_ready",  128'(in_ready),        128'(0));
    chk("bp_out_data",  out_data,              fips(C1_PT));
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    wait_acc(2, "bp");
    in_valid = 1'b0;
    chk("bp_reaccept_gap", 128'(acc_hist[1] - hs_cyc[0]), 128'(1));
    chk("bp_hs_data",      hs_data[0], fips(C1_PT));
    out_ready = 1'b1;
    wait_hs(2, "bp");
    step(1);

    // Back-to-back with both handshakes held high
    base  = acc_hist.size();
    hbase = hs_data.size();
    in_data  = fips(C1_CT);
    in_valid = 1'b1;
    wait_acc(base + 2, "b2b");
    in_valid = 1'b0;
    chk("b2b_spacing", 128'(acc_hist[base + 1] - acc_hist[base]), 128'(12));
    wait_hs(hbase + 2, "b2b");
    chk("b2b_first",  hs_data[hbase],     fips(C1_PT));
    chk("b2b_second", hs_data[hbase + 1], fips(C1_PT));
    step(1);

    // Reset in the fifth cycle after accept, then a fresh block
    base  = acc_hist.size();
    in_data  = fips(C1_CT);
    in_valid = 1'b1;
    wait_acc(base + 1, "rst");
    in_valid = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    hbase = hs_data.size();
    chk("midrst_in_ready",  128'(in_ready),  128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_data",  out_data,        128'(0));
    step(3);
    chk("midrst_no_output", 128'(hs_data.size()), 128'(hbase));
    in_valid = 1'b1;
    wait_acc(base + 2, "postrst");
    in_valid = 1'b0;
    wait_hs(hbase + 1, "postrst");
    chk("postrst_plain", hs_data[hbase], fips(C1_PT));
    step(1);

`ifdef AES_INV_ABORT_EN
    // Abort in the fourth cycle after accept, then abort while idle
    base = acc_hist.size();
    in_valid = 1'b1;
    wait_acc(base + 1, "abort");
    in_valid = 1'b0;
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_busy",     128'(busy),     128'(0));
    b0 = ov_rise.size();
    step(15);
    chk("abort_no_valid", 128'(ov_rise.size()), 128'(b0));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("idle_abort_in_ready", 128'(in_ready), 128'(1));
    chk("idle_abort_rk_idx",   128'(rk_idx),   128'(10));
    step(1);
`endif

    // All-zero key schedule and ciphertext
    for (int r = 0; r < 16; r++) key_store[r] = '0;
    base  = acc_hist.size();
    hbase = hs_data.size();
    b0    = busy_cnt;
    in_data  = '0;
    in_valid = 1'b1;
    wait_acc(base + 1, "zero");
    in_valid = 1'b0;
    wait_hs(hbase + 1, "zero");
    chk("zero_busy_cycles", 128'(busy_cnt - b0), 128'(10));
    chk("zero_plain",       hs_data[hbase], ref_decrypt('0));
    step(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 inverse-cipher controller. It accepts one 128-bit ciphertext block, fetches round keys by index from an external key store, and runs one inverse round per clock through the team's combinational round functions: inverse shift rows, inverse sub bytes, add round key and inverse mix columns. It presents the plaintext on a valid/ready output and sits between the decrypt-side stream interface and the round-key RAM.

## Interface
- NR, default 10: number of cipher rounds (AES-128); sets the round-counter range.
- clk  input  1: rising-edge clock.
- rst  input  1: reset, synchronous, active-high.
- in_valid  input  1: ciphertext block on in_data is valid.
- in_ready  output  1: controller can accept a block; high only in IDLE.
- in_data  input  128: ciphertext block. Byte n of the FIPS-197 byte stream (n = 4c + r, row r, column c) occupies bits [n*8 +: 8].
- rk_idx  output  4: round-key index requested from the key store this cycle.
- rk_data  input  128: round key for rk_idx, returned combinationally in the same cycle; same byte ordering as in_data.
- out_valid  output  1: plaintext on out_data is valid.
- out_ready  input  1: consumer accepts out_data.
- out_data  output  128: plaintext block, registered.
- busy  output  1: high in ROUND and FINAL.
- abort  input  1: present only with AES_INV_ABORT_EN.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1 and rk_idx = NR.
  - On in_valid: load state_q <= in_data ^ rk_data, set rnd_q <= NR-1, go to ROUND.
- ROUND:
  - rk_idx = rnd_q.
  - state_q <= InvMixColumns(InvSubBytes(InvShiftRows(state_q)) ^ rk_data).
  - If rnd_q == 1, go to FINAL; otherwise decrement rnd_q.
- FINAL:
  - rk_idx = 0.
  - out_data <= InvSubBytes(InvShiftRows(state_q)) ^ rk_data, with no InvMixColumns.
  - Set out_valid and go to DONE.
- DONE:
  - out_valid and out_data hold stable until out_ready.
  - On out_ready: clear out_valid, go to IDLE.
  - in_ready is 0, so an input accept never coincides with an output accept.
- InvShiftRows: row r rotates right by r columns, so out(r,c) = in(r,(c-r) mod 4).
- rk_idx is a combinational function of the FSM state and rnd_q; it never glitches outside IDLE/ROUND/FINAL.
- In DONE, rk_idx = NR so the next IDLE key fetch is already presented.
- out_data keeps its last value after the handshake until the next FINAL.

## Timing
- Input accepted at edge T. ROUND runs at cycles T+1..T+9 (keys 9..1), FINAL at T+10, out_valid high from T+11.
- Latency is 11 cycles from accept to out_valid. Peak throughput is one block per 12 cycles when out_ready is held high.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, busy 0, rk_idx NR, rnd_q 0, state_q 0.
- Reset mid-operation (any state): all of the above apply at the next edge. No output handshake completes for the in-flight block.
- in_valid held while not IDLE is ignored; the block is not consumed.
- rnd_q never wraps below 1 in ROUND. An illegal FSM encoding returns to IDLE.

## Configuration
- AES_INV_ABORT_EN defined:
  - Adds the abort input.
  - abort high in ROUND, FINAL or DONE returns to IDLE at the next edge and clears out_valid; out_data is unchanged.
  - abort in IDLE has no effect. abort takes priority over an out_ready that coincides with it.
- Not defined: the port is absent and every accepted block runs to completion.

## Structure
- Shared package aes_pkg holds:
  - block_t (logic [127:0]) and rk_idx_t (logic [3:0]).
  - The AES_NR = 10 constant.
  - The inv_fsm_t enum {IDLE, ROUND, FINAL, DONE}.
  - The inverse S-box function.
- Sub-module aes_inv_round: combinational single inverse round (state_in, rk_in, last_in -> state_out). It instantiates inv_shift_rows, inverse sub bytes, the key XOR and inverse mix columns, and bypasses inverse mix columns when last_in = 1.
- The controller holds the FSM, rnd_q, state_q, the output register and the handshakes.

## Test plan
- FIPS-197 C.1: in_data = 69c4e0d86a7b0430d8cdb78070b4c55a, key schedule from 000102030405060708090a0b0c0d0e0f -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept, rk_idx sequence 10,9,...,1,0.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_data stable, in_ready = 0, a second in_valid is not accepted until one cycle after the out handshake.
- Back-to-back: two C.1 blocks with in_valid and out_ready held high -> both outputs correct, second accept 12 cycles after the first.
- Reset at T+5 of an operation -> next cycle in_ready = 1, out_valid = 0, out_data = 0; a fresh block then decrypts correctly.
- With AES_INV_ABORT_EN: abort at T+4 -> IDLE next cycle, no out_valid pulse; abort in IDLE -> no state change.
- All-zero key schedule and all-zero ciphertext -> output matches the bench reference model; busy high exactly 10 cycles.
